eth_axi_req_master: RTL

ETH_AXI_REQ_MASTER -- requirements
Module: eth_axi_req_master

---
 rtl/eth_rgmii_pkg.sv | 41 ++++
 rtl/eth_axi_req_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rgmii_pkg.sv
// Shared types for the Ethernet block's register/AXI master path.
// Holds the address/data/strobe/id/user widths, the AXI field types used on
// the AW/W/B/AR/R channels and the request-master FSM state encoding.
package eth_rgmii_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned USER_W = 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [ID_W-1:0]   id_t;
  typedef logic [USER_W-1:0] user_t;

  typedef logic [7:0] axi_len_t;
  typedef logic [2:0] axi_size_t;
  typedef logic [1:0] axi_burst_t;
  typedef logic [3:0] axi_cache_t;
  typedef logic [2:0] axi_prot_t;
  typedef logic [3:0] axi_qos_t;
  typedef logic [3:0] axi_region_t;
  typedef logic [5:0] axi_atop_t;
  typedef logic [1:0] axi_resp_t;

  localparam axi_burst_t BURST_INCR = 2'b01;
  // Every beat covers the full data bus.
  localparam axi_size_t  AXI_SIZE   = axi_size_t'($clog2(STRB_W));

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_DRAIN = 3'd5
  } req_state_e;

endpackage

// File: rtl/eth_axi_req_master.sv
// eth_axi_req_master: turns a simple req/gnt register access into a single
// beat AXI4 transaction and returns a one-cycle response pulse.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   req_i/we_i/addr_i/wdata_i/strb_i   requester side, gnt_o accepts (comb)
//   rsp_valid_o/rsp_rdata_o/rsp_err_o  registered completion pulse
//   aw_* / w_* / b_* / ar_* / r_*      AXI4 master channels
//
// Build option: ETH_AXI_REQ_TIMEOUT_EN enables a watchdog that forces an
// error response TIMEOUT_CYCLES after grant and then silently drains the
// outstanding AXI transaction (DRAIN state). Without it, transactions wait
// for the slave indefinitely and DRAIN is never entered.
module eth_axi_req_master
  import eth_rgmii_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // requester
  input  logic        req_i,
  input  logic        we_i,
  input  addr_t       addr_i,
  input  data_t       wdata_i,
  input  strb_t       strb_i,
  output logic        gnt_o,
  output logic        rsp_valid_o,
  output data_t       rsp_rdata_o,
  output logic        rsp_err_o,
  // AW
  output id_t         aw_id,
  output addr_t       aw_addr,
  output axi_len_t    aw_len,
  output axi_size_t   aw_size,
  output axi_burst_t  aw_burst,
  output logic        aw_lock,
  output axi_cache_t  aw_cache,
  output axi_prot_t   aw_prot,
  output axi_qos_t    aw_qos,
  output axi_region_t aw_region,
  output axi_atop_t   aw_atop,
  output user_t       aw_user,
  output logic        aw_valid,
  input  logic        aw_ready,
  // W
  output data_t       w_data,
  output strb_t       w_strb,
  output logic        w_last,
  output user_t       w_user,
  output logic        w_valid,
  input  logic        w_ready,
  // B
  input  id_t         b_id,
  input  axi_resp_t   b_resp,
  input  user_t       b_user,
  input  logic        b_valid,
  output logic        b_ready,
  // AR
  output id_t         ar_id,
  output addr_t       ar_addr,
  output axi_len_t    ar_len,
  output axi_size_t   ar_size,
  output axi_burst_t  ar_burst,
  output logic        ar_lock,
  output axi_cache_t  ar_cache,
  output axi_prot_t   ar_prot,
  output axi_qos_t    ar_qos,
  output axi_region_t ar_region,
  output user_t       ar_user,
  output logic        ar_valid,
  input  logic        ar_ready,
  // R
  input  id_t         r_id,
  input  data_t       r_data,
  input  axi_resp_t   r_resp,
  input  logic        r_last,
  input  user_t       r_user,
  input  logic        r_valid,
  output logic        r_ready
);

  req_state_e state_q, state_d;
  logic       we_q, we_d;
  addr_t      addr_q, addr_d;
  data_t      wdata_q, wdata_d;
  strb_t      strb_q, strb_d;
  // Per-channel "valid still owed" flags; AW and W retire independently.
  logic       aw_pend_q, aw_pend_d;
  logic       w_pend_q, w_pend_d;
  logic       ar_pend_q, ar_pend_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_err_q, rsp_err_d;
  data_t      rsp_rdata_q, rsp_rdata_d;

  logic b_hs, r_hs, ar_hs;

`ifdef ETH_AXI_REQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counter reads 0 in the first cycle after grant, so hitting
  // TIMEOUT_CYCLES-2 there puts the registered pulse TIMEOUT_CYCLES after
  // the grant cycle.
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(TIMEOUT_CYCLES - 2);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;
  logic             active;
`endif

  // Bits of the slave response we never look at.
  logic unused_in;
  assign unused_in = ^{b_id, b_user, b_resp[0], r_id, r_last, r_user, r_resp[0]};

  assign gnt_o = req_i && (state_q == ST_IDLE);

  assign b_hs  = b_valid && b_ready;
  assign r_hs  = r_valid && r_ready;
  assign ar_hs = ar_pend_q && ar_ready;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      ar_pend_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef ETH_AXI_REQ_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      ar_pend_q   <= ar_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef ETH_AXI_REQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    // A pending valid retires on its own handshake in any state.
    aw_pend_d   = aw_pend_q && !aw_ready;
    w_pend_d    = w_pend_q && !w_ready;
    ar_pend_d   = ar_pend_q && !ar_ready;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          strb_d  = strb_i;
          if (we_i) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = ST_WRITE;
          end else begin
            ar_pend_d = 1'b1;
            state_d   = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (!aw_pend_d && !w_pend_d) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        if (b_hs) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = b_resp[1];
        end
      end
      ST_READ: begin
        if (ar_hs) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (r_hs) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = r_resp[1];
          rsp_rdata_d = r_resp[1] ? '0 : r_data;
        end
      end
      ST_DRAIN: begin
        // Response already given; swallow the late B/R quietly.
        if (we_q ? b_hs : r_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef ETH_AXI_REQ_TIMEOUT_EN
    active  = (state_q inside {ST_WRITE, ST_WRESP, ST_READ, ST_RDATA});
    timeout = active && (cnt_q == CNT_HIT);
    if (gnt_o)
      cnt_d = '0;
    else if (active)
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = cnt_q;
    // A real B/R arriving in the timeout cycle takes precedence.
    if (timeout && !rsp_valid_d) begin
      state_d     = ST_DRAIN;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end
`endif
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    b_ready = 1'b0;
    r_ready = 1'b0;
    case (state_q)
      ST_WRESP: b_ready = 1'b1;
      ST_RDATA: r_ready = 1'b1;
      ST_DRAIN: begin
        // Only accept B/R once the address/data side has fully gone out.
        b_ready = we_q && !aw_pend_q && !w_pend_q;
        r_ready = !we_q && !ar_pend_q;
      end
      default: ;
    endcase
  end

  assign aw_valid  = aw_pend_q;
  assign aw_id     = id_t'(AXI_ID);
  assign aw_addr   = addr_q;
  assign aw_len    = '0;
  assign aw_size   = AXI_SIZE;
  assign aw_burst  = BURST_INCR;
  assign aw_lock   = 1'b0;
  assign aw_cache  = '0;
  assign aw_prot   = '0;
  assign aw_qos    = '0;
  assign aw_region = '0;
  assign aw_atop   = '0;
  assign aw_user   = '0;

  assign w_valid   = w_pend_q;
  assign w_data    = wdata_q;
  assign w_strb    = strb_q;
  assign w_last    = 1'b1;
  assign w_user    = '0;

  assign ar_valid  = ar_pend_q;
  assign ar_id     = id_t'(AXI_ID);
  assign ar_addr   = addr_q;
  assign ar_len    = '0;
  assign ar_size   = AXI_SIZE;
  assign ar_burst  = BURST_INCR;
  assign ar_lock   = 1'b0;
  assign ar_cache  = '0;
  assign ar_prot   = '0;
  assign ar_qos    = '0;
  assign ar_region = '0;
  assign ar_user   = '0;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
